bitwise_seq_unit: RTL and testbench

Parametrised, multi-operation successor to the fixed 16-bit bitwise gate banks. Accepts two WIDTH-bit operands and a 3-bit opcode over a valid/ready handshake. Processes the operands SLICE bits per cycle through one shared SLICE-wide gate slice, then presents the WIDTH-bit result and a zero flag over an output valid/ready handshake. Sits between a register or datapath source and the ALU result path where gate area is traded for latency.

---
 rtl/bitwise_seq_unit_pkg.sv | 23 ++
 rtl/bitwise_slice.sv | 28 ++
 rtl/bitwise_seq_unit.sv | 138 +++++++++++++
 tb/tb_bitwise_seq_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bitwise_seq_unit_pkg.sv
// Shared opcode definitions for the bitwise units (also consumed by the ALU).
package bitwise_seq_unit_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'b000;
    localparam op_t OP_OR   = 3'b001;
    localparam op_t OP_XOR  = 3'b010;
    localparam op_t OP_NAND = 3'b011;
    localparam op_t OP_NOR  = 3'b100;
    localparam op_t OP_XNOR = 3'b101;
    localparam op_t OP_NOT  = 3'b110;
    localparam op_t OP_PASS = 3'b111;

    localparam int unsigned NUM_OPS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bitwise_slice.sv
// Combinational SLICE-bit gate bank: every gate evaluated per bit, opcode picks one.
module bitwise_slice
    import bitwise_seq_unit_pkg::*;
#(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  op_t              op,
    output logic [SLICE-1:0] y_c
);

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        logic [NUM_OPS-1:0] gate_c;

        assign gate_c[OP_AND]  = a[i] & b[i];
        assign gate_c[OP_OR]   = a[i] | b[i];
        assign gate_c[OP_XOR]  = a[i] ^ b[i];
        assign gate_c[OP_NAND] = ~(a[i] & b[i]);
        assign gate_c[OP_NOR]  = ~(a[i] | b[i]);
        assign gate_c[OP_XNOR] = ~(a[i] ^ b[i]);
        assign gate_c[OP_NOT]  = ~a[i];
        assign gate_c[OP_PASS] = a[i];

        assign y_c[i] = gate_c[op];
    end

endmodule

// File: rtl/bitwise_seq_unit.sv
// Bit-serial (SLICE bits per cycle) bitwise operation unit with valid/ready on both sides.
module bitwise_seq_unit
    import bitwise_seq_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned SLICE_SAFE = (SLICE > 0) ? SLICE : 1;
    localparam int unsigned NUM_SLICES = WIDTH / SLICE_SAFE;
    localparam int unsigned CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    if ((SLICE < 1) || ((WIDTH % SLICE_SAFE) != 0)) begin : g_param_check
        $error("bitwise_seq_unit: WIDTH must be a nonzero multiple of SLICE");
    end

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    op_t                    op_q, op_d;
    logic [WIDTH-1:0]       result_d;
    logic                   zero_d;
    logic                   out_valid_d;
    logic                   in_ready_d;
    logic [SLICE_SAFE-1:0]  slice_a_c, slice_b_c, slice_y_c;

    // Select the operand slice addressed by the counter.
    always_comb begin
        slice_a_c = '0;
        slice_b_c = '0;
        for (int s = 0; s < NUM_SLICES; s++) begin
            if (cnt_q == CNT_W'(s)) begin
                slice_a_c = a_q[s*SLICE_SAFE +: SLICE_SAFE];
                slice_b_c = b_q[s*SLICE_SAFE +: SLICE_SAFE];
            end
        end
    end

    bitwise_slice #(
        .SLICE (SLICE_SAFE)
    ) u_slice (
        .a   (slice_a_c),
        .b   (slice_b_c),
        .op  (op_q),
        .y_c (slice_y_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        result_d    = result;
        zero_d      = zero;
        out_valid_d = out_valid;
        in_ready_d  = in_ready;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d        = a;
                    b_d        = b;
                    op_d       = op;
                    result_d   = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int s = 0; s < NUM_SLICES; s++) begin
                    if (cnt_q == CNT_W'(s)) begin
                        result_d[s*SLICE_SAFE +: SLICE_SAFE] = slice_y_c;
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NUM_SLICES - 1)) begin
                    cnt_d       = '0;
                    zero_d      = (result_d == '0);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_AND;
            result    <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            result    <= result_d;
            zero      <= zero_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_bitwise_seq_unit.sv
// Randomised self-checking bench for bitwise_seq_unit at three WIDTH/SLICE points.
module tb_bitwise_seq_unit;
    import bitwise_seq_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Index 0: W16/S4, 1: W16/S16, 2: W32/S8
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    logic [2:0]  op_v [3];
    logic [2:0]  iv_v;
    logic [2:0]  ordy_v;

    logic        ir0, ov0, z0, ir1, ov1, z1, ir2, ov2, z2;
    logic [15:0] r0, r1;
    logic [31:0] r2;
    logic [2:0]  ir_v, ov_v, z_v;
    logic [31:0] r_v [3];

    assign ir_v   = {ir2, ir1, ir0};
    assign ov_v   = {ov2, ov1, ov0};
    assign z_v    = {z2, z1, z0};
    assign r_v[0] = {16'h0000, r0};
    assign r_v[1] = {16'h0000, r1};
    assign r_v[2] = r2;

    bitwise_seq_unit #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[0]), .in_ready(ir0),
        .a(a_v[0][15:0]), .b(b_v[0][15:0]), .op(op_v[0]),
        .out_valid(ov0), .out_ready(ordy_v[0]), .result(r0), .zero(z0));

    bitwise_seq_unit #(.WIDTH(16), .SLICE(16)) dut_s16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[1]), .in_ready(ir1),
        .a(a_v[1][15:0]), .b(b_v[1][15:0]), .op(op_v[1]),
        .out_valid(ov1), .out_ready(ordy_v[1]), .result(r1), .zero(z1));

    bitwise_seq_unit #(.WIDTH(32), .SLICE(8)) dut_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[2]), .in_ready(ir2),
        .a(a_v[2]), .b(b_v[2]), .op(op_v[2]),
        .out_valid(ov2), .out_ready(ordy_v[2]), .result(r2), .zero(z2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: whole-word bitwise result per opcode, masked to width.
    function automatic logic [31:0] model(input int w, input logic [2:0] o,
                                          input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        case (o)
            3'd0:    r = x & y;
            3'd1:    r = x | y;
            3'd2:    r = x ^ y;
            3'd3:    r = ~(x & y);
            3'd4:    r = ~(x | y);
            3'd5:    r = ~(x ^ y);
            3'd6:    r = ~x;
            default: r = x;
        endcase
        return (w == 32) ? r : (r & 32'h0000FFFF);
    endfunction

    task automatic run_op(input int k, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [2:0] xo, input int bp, input string tag);
        int w, ns, lat, guard;
        logic [31:0] exp, held;
        w   = (k == 2) ? 32 : 16;
        ns  = (k == 1) ? 1 : 4;
        exp = model(w, xo, xa, xb);
        guard = 0;
        while (ir_v[k] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ":ready"}, 32'(ir_v[k]), 32'd1);
        a_v[k] = xa; b_v[k] = xb; op_v[k] = xo;
        iv_v[k] = 1'b1;
        ordy_v[k] = (bp == 0);
        @(negedge clk);
        iv_v[k] = 1'b0;
        a_v[k] = $urandom; b_v[k] = $urandom; op_v[k] = 3'($urandom);
        check({tag, ":busy"}, 32'(ir_v[k]), 32'd0);
        lat = 0;
        while (ov_v[k] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), 32'(ns));
        check({tag, ":result"}, r_v[k], exp);
        check({tag, ":zero"}, 32'(z_v[k]), 32'(exp == 32'd0));
        held = r_v[k];
        for (int i = 0; i < bp; i++) begin
            iv_v[k] = 1'($urandom);
            a_v[k] = $urandom;
            @(negedge clk);
            check({tag, ":hold_result"}, r_v[k], held);
            check({tag, ":hold_flags"}, 32'({ov_v[k], ir_v[k]}), 32'd2);
        end
        iv_v[k] = 1'b0;
        ordy_v[k] = 1'b1;
        @(negedge clk);
        check({tag, ":release"}, 32'({ov_v[k], ir_v[k]}), 32'd1);
        ordy_v[k] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            a_v[k] = '0; b_v[k] = '0; op_v[k] = '0;
        end
        iv_v = '0;
        ordy_v = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_flags", 32'({ov_v[k], ir_v[k], z_v[k]}), 32'd2);
            check("reset_result", r_v[k], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 32'hF0F0, 32'hFF00, OP_AND, 0, "and_basic");
        for (int o = 0; o < 8; o++) run_op(0, 32'h0F0F, 32'h00FF, 3'(o), 0, "sweep");
        run_op(0, 32'h00FF, 32'hFF00, OP_AND, 0, "zero_flag");
        run_op(0, $urandom, $urandom, OP_XOR, 10, "backpressure");

        // Asynchronous reset two cycles into RUN
        a_v[0] = 32'hFFFF; b_v[0] = 32'hFFFF; op_v[0] = OP_AND;
        iv_v[0] = 1'b1;
        @(negedge clk);
        iv_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_flags", 32'({ov0, ir0}), 32'd1);
        check("midrun_reset_result", r_v[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 32'h0001, 32'h0002, OP_OR, 0, "after_reset");

        run_op(1, 32'hA5A5, 32'h0FF0, OP_NAND, 0, "s16_nand");
        run_op(2, 32'hDEADBEEF, 32'hFFFFFFFF, OP_XOR, 0, "w32_xor");

        for (int n = 0; n < 60; n++) begin
            run_op($urandom_range(0, 2), $urandom, $urandom, 3'($urandom),
                   $urandom_range(0, 3), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
